// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared codes, ROM field indices and FSM states for battle_ctrl
package battle_pkg;

    // Elemental type codes as stored in the ROM (type effectiveness is not evaluated)
    localparam logic [7:0] TYPE_NORMAL   = 8'd0;
    localparam logic [7:0] TYPE_POISON   = 8'd3;
    localparam logic [7:0] TYPE_ELECTRIC = 8'd13;
    localparam logic [7:0] TYPE_PSYCHIC  = 8'd14;

    // Move category codes
    localparam logic [7:0] CAT_SPECIAL  = 8'd0;
    localparam logic [7:0] CAT_PHYSICAL = 8'd1;

    // Byte indices into the Pokemon record
    localparam int PK_TYPE1 = 11;
    localparam int PK_TYPE2 = 10;
    localparam int PK_HP    = 9;
    localparam int PK_ATK   = 8;
    localparam int PK_DEF   = 7;
    localparam int PK_SPA   = 6;
    localparam int PK_SPD   = 5;
    localparam int PK_SPE   = 4;
    localparam int PK_MOVE0 = 3;

    // Byte indices into the move record
    localparam int MV_TYPE = 4;
    localparam int MV_CAT  = 3;
    localparam int MV_POW  = 2;
    localparam int MV_ACC  = 1;
    localparam int MV_PP   = 0;

    // Accuracy at or above this value never misses
    localparam logic [7:0] ACC_ALWAYS = 8'd100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_FETCH,
        ST_ATK_A,
        ST_ATK_B,
        ST_DONE
    } battle_state_t;

endpackage

// File: rtl/damage_calc.sv
// rtl/damage_calc.sv - combinational damage: (power*atk)>>6 minus half defense, floor 1, cap 255
module damage_calc (
    input  logic [7:0] power,
    input  logic [7:0] atk,
    input  logic [7:0] def,
    output logic [7:0] dmg
);

    logic [15:0] prod;
    logic [9:0]  base;
    logic [9:0]  half;
    logic [9:0]  d;
    logic        unused_low_bits;

    assign unused_low_bits = ^{prod[5:0], def[0]};

    // Scale attack by power, subtract half the defense, then clamp to 1..255
    always_comb begin
        prod = {8'd0, power} * {8'd0, atk};
        base = prod[15:6];
        half = {3'd0, def[7:1]};
        if (base > half) begin
            d = base - half;
        end else begin
            d = 10'd1;
        end
        dmg = (d > 10'd255) ? 8'hFF : d[7:0];
    end

endmodule

// File: rtl/battle_ctrl.sv
// rtl/battle_ctrl.sv - two-player turn sequencer owning HP/PP state and the stats ROM address ports
module battle_ctrl
    import battle_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             new_battle,
    input  logic [2:0]       p1_mon,
    input  logic [2:0]       p2_mon,
    input  logic             turn_go,
    input  logic [1:0]       p1_slot,
    input  logic [1:0]       p2_slot,
    output logic [2:0]       pokemon_addr1,
    output logic [2:0]       pokemon_addr2,
    output logic [4:0]       move_addr1,
    output logic [4:0]       move_addr2,
    input  logic [11:0][7:0] pokemon_data1,
    input  logic [11:0][7:0] pokemon_data2,
    input  logic [4:0][7:0]  move_data1,
    input  logic [4:0][7:0]  move_data2,
    output logic             busy,
    output logic             ready,
    output logic             turn_done,
    output logic             first_is_p2,
    output logic [1:0]       hit,
    output logic [7:0]       p1_hp,
    output logic [7:0]       p2_hp,
    output logic [3:0][7:0]  p1_pp,
    output logic [3:0][7:0]  p2_pp,
    output logic [1:0]       winner
);

    battle_state_t state_q, state_d;
    logic          load_go, turn_ok;
    logic [1:0]    k_q;
    logic [1:0]    slot1_q, slot2_q;
    logic [7:0]    lfsr_q;

    // Per-side move fields and stats captured in FETCH; dfn is this side's defence against the opponent's move
    logic [7:0]    pow1_q, acc1_q, atk1_q, dfn1_q;
    logic [7:0]    pow2_q, acc2_q, atk2_q, dfn2_q;

    // Current attacker view, muxed by attack phase and turn order
    logic          atk_p2;
    logic [7:0]    a_pp, a_hp, d_hp, a_pow, a_acc, a_atk, d_def;
    logic [7:0]    dmg, d_hp_next;
    logic          a_valid, a_hit;

    logic          unused_rom_bits;

    assign unused_rom_bits = ^{pokemon_data1[PK_TYPE1:PK_TYPE2], pokemon_data2[PK_TYPE1:PK_TYPE2],
                               move_data1[MV_TYPE], move_data2[MV_TYPE],
                               pokemon_data1[3][7:5], pokemon_data1[2][7:5],
                               pokemon_data1[1][7:5], pokemon_data1[0][7:5],
                               pokemon_data2[3][7:5], pokemon_data2[2][7:5],
                               pokemon_data2[1][7:5], pokemon_data2[0][7:5]};

    assign busy      = (state_q == ST_LOAD) || (state_q == ST_FETCH) || (state_q == ST_ATK_A) ||
                       (state_q == ST_ATK_B) || (state_q == ST_DONE);
    assign ready     = (state_q == ST_READY) && (winner == 2'b00);
    assign turn_done = (state_q == ST_DONE);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; new_battle outranks turn_go and both only matter in IDLE/READY
    always_comb begin
        state_d = state_q;
        load_go = 1'b0;
        turn_ok = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_battle) begin
                    load_go = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (k_q == 2'd3) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (new_battle) begin
                    load_go = 1'b1;
                    state_d = ST_LOAD;
                end else if (turn_go && (winner == 2'b00)) begin
                    turn_ok = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_ATK_A;
            ST_ATK_A: state_d = ST_ATK_B;
            ST_ATK_B: state_d = ST_DONE;
            ST_DONE:  state_d = ST_READY;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Move ROM addressing: slot k while loading PP, selected slot while fetching; slot 0 lives at byte 3
    always_comb begin
        move_addr1 = 5'd0;
        move_addr2 = 5'd0;
        if (state_q == ST_LOAD) begin
            move_addr1 = pokemon_data1[{2'b00, ~k_q}][4:0];
            move_addr2 = pokemon_data2[{2'b00, ~k_q}][4:0];
        end else if (state_q == ST_FETCH) begin
            move_addr1 = pokemon_data1[{2'b00, ~slot1_q}][4:0];
            move_addr2 = pokemon_data2[{2'b00, ~slot2_q}][4:0];
        end
    end

    // Select attacker/defender operands and evaluate validity, hit and resulting defender HP
    always_comb begin
        atk_p2 = (state_q == ST_ATK_A) ? first_is_p2 : ~first_is_p2;
        if (atk_p2) begin
            a_pp  = p2_pp[slot2_q];
            a_hp  = p2_hp;
            d_hp  = p1_hp;
            a_pow = pow2_q;
            a_acc = acc2_q;
            a_atk = atk2_q;
            d_def = dfn1_q;
        end else begin
            a_pp  = p1_pp[slot1_q];
            a_hp  = p1_hp;
            d_hp  = p2_hp;
            a_pow = pow1_q;
            a_acc = acc1_q;
            a_atk = atk1_q;
            d_def = dfn2_q;
        end
        a_valid   = (a_pp != 8'd0) && (a_hp != 8'd0);
        a_hit     = a_valid && ((a_acc >= ACC_ALWAYS) || ({1'b0, lfsr_q[6:0]} < a_acc));
        d_hp_next = (dmg >= d_hp) ? 8'd0 : (d_hp - dmg);
    end

    damage_calc u_damage_calc (
        .power (a_pow),
        .atk   (a_atk),
        .def   (d_def),
        .dmg   (dmg)
    );

    // Battle state registers, LFSR and per-turn capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q        <= LFSR_SEED;
            pokemon_addr1 <= 3'd0;
            pokemon_addr2 <= 3'd0;
            k_q           <= 2'd0;
            slot1_q       <= 2'd0;
            slot2_q       <= 2'd0;
            pow1_q        <= 8'd0;
            acc1_q        <= 8'd0;
            atk1_q        <= 8'd0;
            dfn1_q        <= 8'd0;
            pow2_q        <= 8'd0;
            acc2_q        <= 8'd0;
            atk2_q        <= 8'd0;
            dfn2_q        <= 8'd0;
            first_is_p2   <= 1'b0;
            hit           <= 2'b00;
            p1_hp         <= 8'd0;
            p2_hp         <= 8'd0;
            p1_pp         <= '0;
            p2_pp         <= '0;
            winner        <= 2'b00;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (load_go) begin
                pokemon_addr1 <= p1_mon;
                pokemon_addr2 <= p2_mon;
                k_q           <= 2'd0;
            end
            if (turn_ok) begin
                slot1_q <= p1_slot;
                slot2_q <= p2_slot;
            end
            case (state_q)
                ST_LOAD: begin
                    p1_pp[k_q] <= move_data1[MV_PP];
                    p2_pp[k_q] <= move_data2[MV_PP];
                    k_q        <= k_q + 2'd1;
                    if (k_q == 2'd0) begin
                        p1_hp  <= pokemon_data1[PK_HP];
                        p2_hp  <= pokemon_data2[PK_HP];
                        winner <= 2'b00;
                        hit    <= 2'b00;
                    end
                end
                ST_FETCH: begin
                    pow1_q      <= move_data1[MV_POW];
                    acc1_q      <= move_data1[MV_ACC];
                    atk1_q      <= (move_data1[MV_CAT] == CAT_PHYSICAL) ? pokemon_data1[PK_ATK] : pokemon_data1[PK_SPA];
                    dfn1_q      <= (move_data2[MV_CAT] == CAT_PHYSICAL) ? pokemon_data1[PK_DEF] : pokemon_data1[PK_SPD];
                    pow2_q      <= move_data2[MV_POW];
                    acc2_q      <= move_data2[MV_ACC];
                    atk2_q      <= (move_data2[MV_CAT] == CAT_PHYSICAL) ? pokemon_data2[PK_ATK] : pokemon_data2[PK_SPA];
                    dfn2_q      <= (move_data1[MV_CAT] == CAT_PHYSICAL) ? pokemon_data2[PK_DEF] : pokemon_data2[PK_SPD];
                    first_is_p2 <= (pokemon_data2[PK_SPE] > pokemon_data1[PK_SPE]);
                    hit         <= 2'b00;
                end
                ST_ATK_A, ST_ATK_B: begin
                    if (a_valid) begin
                        if (atk_p2) begin
                            p2_pp[slot2_q] <= a_pp - 8'd1;
                        end else begin
                            p1_pp[slot1_q] <= a_pp - 8'd1;
                        end
                        if (a_hit) begin
                            if (atk_p2) begin
                                p1_hp  <= d_hp_next;
                                hit[1] <= 1'b1;
                            end else begin
                                p2_hp  <= d_hp_next;
                                hit[0] <= 1'b1;
                            end
                            if (d_hp_next == 8'd0) begin
                                winner <= atk_p2 ? 2'b10 : 2'b01;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
